// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: start bit, data word, optional even parity, stop bits.
// One bit advances per enabled clock; the line idles low.
module serial_bit_tx #(
  parameter int unsigned DATA_W    = 8,
  parameter bit          MSB_FIRST = 1'b0,
  parameter bit          PARITY_EN = 1'b1,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              i_clk,
  input  logic              i_clr,
  input  logic              i_enable,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_q,
  output logic              o_busy,
  output logic              o_done
);

  localparam int unsigned DataCntW = $clog2(DATA_W + 1);
  // The same counter also times the stop bits, which need up to 3 bits.
  localparam int unsigned CntW     = (DataCntW > 3) ? DataCntW : 3;

  if (STOP_BITS < 1 || STOP_BITS > 4) begin : g_stop_bits_check
    $error("serial_bit_tx: STOP_BITS must be in 1..4, got %0d", STOP_BITS);
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              q_q, q_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              next_bit;
  logic [DATA_W-1:0] shift_adv;

  // The next data bit to send always sits at the outgoing end of the shift register.
  assign next_bit  = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
  assign shift_adv = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);

  assign o_ready = (state_q == StIdle) & i_enable & ~i_clr;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    q_d     = q_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (i_valid && o_ready) begin
          state_d = StStart;
          shift_d = i_data;
          par_d   = ^i_data;
          cnt_d   = '0;
          q_d     = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StStart: begin
        if (i_enable) begin
          state_d = StData;
          q_d     = next_bit;
          shift_d = shift_adv;
          cnt_d   = CntW'(1);
        end
      end
      StData: begin
        if (i_enable) begin
          if (cnt_q == CntW'(DATA_W)) begin
            if (PARITY_EN) begin
              state_d = StParity;
              q_d     = par_q;
            end else begin
              state_d = StStop;
              q_d     = 1'b0;
              cnt_d   = CntW'(1);
            end
          end else begin
            q_d     = next_bit;
            shift_d = shift_adv;
            cnt_d   = cnt_q + CntW'(1);
          end
        end
      end
      StParity: begin
        if (i_enable) begin
          state_d = StStop;
          q_d     = 1'b0;
          cnt_d   = CntW'(1);
        end
      end
      StStop: begin
        if (i_enable) begin
          if (cnt_q == CntW'(STOP_BITS)) begin
            state_d = StIdle;
            q_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
        q_d     = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      q_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign o_q    = q_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: an LSB-first/1-stop instance and an MSB-first/2-stop instance
// share stimulus and are compared against a frame-list reference model.
module tb_serial_bit_tx;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       enable = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;

  logic ready0, q0, busy0, done0;
  logic ready1, q1, busy1, done1;

  int n_checks = 0;
  int n_pass   = 0;

  always #10 clk = ~clk;

  serial_bit_tx dut0 (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_enable(enable),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ready0),
    .o_q     (q0),
    .o_busy  (busy0),
    .o_done  (done0)
  );

  serial_bit_tx #(
    .DATA_W   (8),
    .MSB_FIRST(1'b1),
    .PARITY_EN(1'b1),
    .STOP_BITS(2)
  ) dut1 (
    .i_clk   (clk),
    .i_clr   (clr),
    .i_enable(enable),
    .i_valid (valid),
    .i_data  (data),
    .o_ready (ready1),
    .o_q     (q1),
    .o_busy  (busy1),
    .o_done  (done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: each accepted word becomes an explicit list of line values.
  bit   m_active[2] = '{1'b0, 1'b0};
  int   m_idx[2]    = '{0, 0};
  int   m_len[2]    = '{0, 0};
  bit   m_frm[2][16];
  logic m_q[2]      = '{1'b0, 1'b0};
  logic m_busy[2]   = '{1'b0, 1'b0};
  logic m_done[2]   = '{1'b0, 1'b0};

  task automatic build_frame(input int i, input logic [7:0] d);
    int pos;
    int stops;
    bit msb;
    msb   = (i == 1);
    stops = (i == 1) ? 2 : 1;
    m_frm[i][0] = 1'b1;
    pos = 1;
    for (int b = 0; b < 8; b++) begin
      m_frm[i][pos] = msb ? d[7-b] : d[b];
      pos++;
    end
    m_frm[i][pos] = ^d;
    pos++;
    for (int s = 0; s < stops; s++) begin
      m_frm[i][pos] = 1'b0;
      pos++;
    end
    m_len[i] = pos;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (clr) begin
        m_active[i] = 1'b0;
        m_idx[i]    = 0;
        m_q[i]      = 1'b0;
        m_busy[i]   = 1'b0;
        m_done[i]   = 1'b0;
      end else begin
        m_done[i] = 1'b0;
        if (m_active[i]) begin
          if (enable) begin
            m_idx[i]++;
            if (m_idx[i] == m_len[i]) begin
              m_active[i] = 1'b0;
              m_q[i]      = 1'b0;
              m_busy[i]   = 1'b0;
              m_done[i]   = 1'b1;
            end else begin
              m_q[i] = m_frm[i][m_idx[i]];
            end
          end
        end else if (enable && valid) begin
          build_frame(i, data);
          m_idx[i]    = 0;
          m_active[i] = 1'b1;
          m_q[i]      = m_frm[i][0];
          m_busy[i]   = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk or posedge clr) model_step();

  always @(negedge clk) begin
    check("mon_q0", q0, m_q[0]);
    check("mon_busy0", busy0, m_busy[0]);
    check("mon_done0", done0, m_done[0]);
    check("mon_ready0", ready0, !m_active[0] && enable && !clr);
    check("mon_q1", q1, m_q[1]);
    check("mon_busy1", busy1, m_busy[1]);
    check("mon_done1", done1, m_done[1]);
    check("mon_ready1", ready1, !m_active[1] && enable && !clr);
  end

  typedef struct {
    logic [7:0]  d;
    logic [10:0] e0;  // LSB-first, 1 stop; first bit on the line is the MSB here
    logic [11:0] e1;  // MSB-first, 2 stops
  } vec_t;

  vec_t vecs[6];

  task automatic idle(input int n);
    enable = 1'b1;
    valid  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1ns after an edge with both transmitters idle.
  task automatic send_check(input string tag, input logic [7:0] d, input logic [10:0] e0,
                            input logic [11:0] e1);
    logic [10:0] g0;
    logic [11:0] g1;
    logic        dn0, dn1;
    g0 = '0;
    g1 = '0;
    dn0 = 1'b0;
    dn1 = 1'b0;
    data   = d;
    valid  = 1'b1;
    enable = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) valid = 1'b0;
      if (c < 11) g0 = {g0[9:0], q0};
      if (c < 12) g1 = {g1[10:0], q1};
      if (c == 11) dn0 = done0;
      if (c == 12) dn1 = done1;
    end
    check({tag, "_stream0"}, g0, e0);
    check({tag, "_stream1"}, g1, e1);
    check({tag, "_done0"}, dn0, 1'b1);
    check({tag, "_done1"}, dn1, 1'b1);
  endtask

  initial begin
    logic [12:0] s13;
    logic [13:0] s14;
    logic [22:0] s23;
    logic [11:0] s12;
    logic        d_a, d_b, d_c;

    vecs[0] = '{8'hA5, 11'b11010010100, 12'b110100101000};
    vecs[1] = '{8'h01, 11'b11000000010, 12'b100000001100};
    vecs[2] = '{8'hFF, 11'b11111111100, 12'b111111111000};
    vecs[3] = '{8'h00, 11'b10000000000, 12'b100000000000};
    vecs[4] = '{8'h3C, 11'b10011110000, 12'b100111100000};
    vecs[5] = '{8'h80, 11'b10000000110, 12'b110000000100};

    // Reset with enable high: o_ready must still be low.
    enable = 1'b1;
    #1 clr = 1'b1;
    #4;
    check("rst_q0", q0, 1'b0);
    check("rst_busy0", busy0, 1'b0);
    check("rst_ready0", ready0, 1'b0);
    check("rst_q1", q1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_ready1", ready1, 1'b0);
    #10 clr = 1'b0;
    #1;
    check("post_rst_ready0", ready0, 1'b1);
    check("post_rst_ready1", ready1, 1'b1);
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      send_check($sformatf("vec%0d", v), vecs[v].d, vecs[v].e0, vecs[v].e1);
    end

    // Enable low for two edges while data bit 3 is on the line; i_valid pulse ignored.
    s13 = '0;
    s14 = '0;
    d_a = 1'b0;
    d_b = 1'b0;
    data  = 8'hA5;
    valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (c < 13) s13 = {s13[11:0], q0};
      if (c < 14) s14 = {s14[12:0], q1};
      if (c == 13) d_a = done0;
      if (c == 14) d_b = done1;
      if (c == 0) valid = 1'b0;
      if (c == 4) begin
        enable = 1'b0;
        valid  = 1'b1;
        data   = 8'h00;
      end
      if (c == 5) valid = 1'b0;
      if (c == 6) enable = 1'b1;
    end
    check("stall_stream0", s13, 13'b1101000010100);
    check("stall_stream1", s14, 14'b11010000101000);
    check("stall_done0", d_a, 1'b1);
    check("stall_done1", d_b, 1'b1);
    idle(4);

    // Back-to-back with i_valid held: FF then 00, one idle gap on the line.
    s23 = '0;
    s12 = '0;
    d_a = 1'b0;
    d_b = 1'b0;
    d_c = 1'b0;
    data  = 8'hFF;
    valid = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (c < 23) s23 = {s23[21:0], q0};
      if (c < 12) s12 = {s12[10:0], q1};
      if (c == 11) d_a = done0;
      if (c == 23) d_b = done0;
      if (c == 12) d_c = done1;
      if (c == 0) data = 8'h00;
      if (c == 12) valid = 1'b0;
    end
    check("b2b_stream0", s23, 23'b11111111100010000000000);
    check("b2b_stream1", s12, 12'b111111111000);
    check("b2b_done0_first", d_a, 1'b1);
    check("b2b_done0_second", d_b, 1'b1);
    check("b2b_done1", d_c, 1'b1);
    idle(16);

    // Asynchronous reset in the middle of the data bits.
    data  = 8'h3C;
    valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) valid = 1'b0;
    end
    check("pre_abort_busy0", busy0, 1'b1);
    #4 clr = 1'b1;
    #1;
    check("abort_q0", q0, 1'b0);
    check("abort_busy0", busy0, 1'b0);
    check("abort_q1", q1, 1'b0);
    check("abort_busy1", busy1, 1'b0);
    check("abort_ready0", ready0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #5 clr = 1'b0;
    @(posedge clk);
    #1;
    send_check("recover", 8'h3C, 11'b10011110000, 12'b100111100000);

    // Random traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      clr    = ($urandom_range(0, 149) == 0);
      enable = ($urandom_range(0, 7) != 0);
      valid  = ($urandom_range(0, 2) != 0);
      data   = 8'($urandom);
    end
    clr = 1'b0;
    idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
